// File: rtl/iob_reg_seq_pkg.sv
// Shared opcodes, error codes and FSM encoding for the
// IOb register command sequencer.
package iob_reg_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_READ     = 2'd1,
    OP_READ_CMP = 2'd2,
    OP_END      = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_CMP     = 2'd2,
    ERR_ABORT   = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int OP_W = 2;

  // Slot layout is {op, addr, data, strb}, MSB first.
  function automatic int cmd_w(input int addr_w, input int data_w);
    return OP_W + addr_w + data_w + data_w / 8;
  endfunction

  localparam int CMD_W = cmd_w(16, 32);

endpackage

// File: rtl/iob_reg_seq_mem.sv
// Command slot register file: one write port and one
// registered read port.
module iob_reg_seq_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 54
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) rdata_q <= '0;
    else        rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/iob_reg_seq.sv
// IOb-native bus master replaying a programmed list of
// write / read / read-compare commands.
module iob_reg_seq
  import iob_reg_seq_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int TIMEOUT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     cmd_we,
  input  logic [$clog2(DEPTH)-1:0] cmd_idx,
  input  logic [1:0]               cmd_op,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic [DATA_W/8-1:0]      cmd_strb,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               error,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic [DATA_W-1:0]        last_rdata,
  output logic                     m_valid,
  output logic [ADDR_W-1:0]        m_address,
  output logic [DATA_W-1:0]        m_wdata,
  output logic [DATA_W/8-1:0]      m_wstrb,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic                     m_ready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SW    = DATA_W / 8;
  localparam int CW    = cmd_w(ADDR_W, DATA_W);
  localparam logic [IDX_W-1:0]     LAST = IDX_W'(DEPTH - 1);
  localparam logic [TIMEOUT_W-1:0] TMAX = '1;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  op_e                    op_q, op_d;
  logic [SW-1:0]          strb_q, strb_d;
  logic                   abort_q, abort_d;
  logic [1:0]             error_q, error_d;
  logic [IDX_W-1:0]       err_idx_q, err_idx_d;
  logic [DATA_W-1:0]      last_rdata_q, last_rdata_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [SW-1:0]          wstrb_q, wstrb_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [CW-1:0]          mem_rdata;
  op_e                    r_op;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_data;
  logic [SW-1:0]          r_strb;
  logic [DATA_W-1:0]      mask;
  logic                   hs;
  logic                   is_rd;
  logic                   mism;

  // Read address follows the next pointer so FETCH sees its slot.
  iob_reg_seq_mem #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_mem (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .we     (cmd_we & ~busy_q),
    .waddr  (cmd_idx),
    .wdata  ({cmd_op, cmd_addr, cmd_data, cmd_strb}),
    .raddr  (ptr_d),
    .rdata  (mem_rdata)
  );

  assign r_op   = op_e'(mem_rdata[CW-1 -: OP_W]);
  assign r_addr = mem_rdata[CW-OP_W-1 -: ADDR_W];
  assign r_data = mem_rdata[SW +: DATA_W];
  assign r_strb = mem_rdata[SW-1:0];

  always_comb begin
    mask = '0;
    for (int i = 0; i < SW; i++) mask[i*8 +: 8] = {8{strb_q[i]}};
  end

  assign hs    = valid_q & m_ready;
  assign is_rd = (op_q != OP_WRITE);
  assign mism  = (op_q == OP_READ_CMP) &&
                 ((m_rdata & mask) != (wdata_q & mask));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    strb_d       = strb_q;
    abort_d      = abort_q;
    error_d      = error_q;
    err_idx_d    = err_idx_q;
    last_rdata_d = last_rdata_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          ptr_d     = '0;
          cnt_d     = '0;
          abort_d   = 1'b0;
          error_d   = ERR_NONE;
          err_idx_d = '0;
        end
      end
      FETCH: begin
        op_d    = r_op;
        addr_d  = r_addr;
        wdata_d = r_data;
        strb_d  = r_strb;
        wstrb_d = (r_op == OP_WRITE) ? r_strb : '0;
        cnt_d   = '0;
        if (r_op == OP_END) begin
          state_d = DONE;
        end else if (abort) begin
          state_d   = DONE;
          error_d   = ERR_ABORT;
          err_idx_d = ptr_q;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (abort) abort_d = 1'b1;
        if (hs) begin
          if (is_rd) last_rdata_d = m_rdata;
          if (mism) begin
            state_d   = DONE;
            error_d   = ERR_CMP;
            err_idx_d = ptr_q;
          end else if (abort_q || abort) begin
            state_d   = DONE;
            error_d   = ERR_ABORT;
            err_idx_d = ptr_q;
          end else if (ptr_q == LAST) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            ptr_d   = ptr_q + 1'b1;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TMAX) begin
            state_d   = DONE;
            error_d   = ERR_TIMEOUT;
            err_idx_d = ptr_q;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == REQ);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      op_q         <= OP_WRITE;
      strb_q       <= '0;
      abort_q      <= 1'b0;
      error_q      <= '0;
      err_idx_q    <= '0;
      last_rdata_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      strb_q       <= strb_d;
      abort_q      <= abort_d;
      error_q      <= error_d;
      err_idx_q    <= err_idx_d;
      last_rdata_q <= last_rdata_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_idx    = err_idx_q;
  assign last_rdata = last_rdata_q;
  assign m_valid    = valid_q;
  assign m_address  = addr_q;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = wstrb_q;

endmodule

// File: tb/tb_iob_reg_seq.sv
// Bench for iob_reg_seq: scripted command lists against a
// latency-programmable IOb slave with a transaction scoreboard.
module tb_iob_reg_seq;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int TW = 4;
  localparam int IW = 3;
  localparam int SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b1;
  logic          cmd_we = 1'b0;
  logic [IW-1:0] cmd_idx = '0;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [1:0]    error;
  logic [IW-1:0] err_idx;
  logic [DW-1:0] last_rdata;
  logic          m_valid;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ready = 1'b0;

  iob_reg_seq #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT_W(TW)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i), .cmd_we(cmd_we),
    .cmd_idx(cmd_idx), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_strb(cmd_strb), .start(start),
    .abort(abort), .busy(busy), .done(done), .error(error),
    .err_idx(err_idx), .last_rdata(last_rdata),
    .m_valid(m_valid), .m_address(m_address),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    bit            chkd;
  } txn_t;

  txn_t exp_q[$];
  txn_t e;
  int   tests = 0;
  int   fails = 0;
  int   hs_cnt = 0;
  int   vcnt = 0;
  int   wcnt = 0;
  int   lat = 0;
  bit   never = 1'b0;
  bit   seen;

  // Slave + monitor: decide ready for the coming edge, then
  // score the handshake that edge will complete.
  always @(negedge clk_i) begin
    if (m_valid) begin
      vcnt++;
      m_ready = !never && (wcnt >= lat);
      if (m_ready) begin
        hs_cnt++;
        wcnt = 0;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL txn_unexpected addr=%h wdata=%h wstrb=%h required none",
                   m_address, m_wdata, m_wstrb);
        end else begin
          e = exp_q.pop_front();
          if (m_address !== e.a || m_wstrb !== e.s ||
              (e.chkd && m_wdata !== e.d)) begin
            fails++;
            $display("FAIL txn got a=%h d=%h s=%h required a=%h d=%h s=%h",
                     m_address, m_wdata, m_wstrb, e.a, e.d, e.s);
          end
        end
      end else begin
        wcnt++;
      end
    end else begin
      m_ready = 1'b0;
      wcnt = 0;
    end
  end

  function automatic void push_exp(input logic [AW-1:0] a,
                                   input logic [DW-1:0] d,
                                   input logic [SW-1:0] s,
                                   input bit chkd);
    txn_t t;
    t.a = a; t.d = d; t.s = s; t.chkd = chkd;
    exp_q.push_back(t);
  endfunction

  task automatic prog(input int idx, input logic [1:0] op,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s);
    @(negedge clk_i);
    cmd_we = 1'b1; cmd_idx = IW'(idx); cmd_op = op;
    cmd_addr = a; cmd_data = d; cmd_strb = s;
    @(negedge clk_i);
    cmd_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_done got none required pulse within 400 cycles", name);
    end
  endtask

  task automatic check_err(input string name, input logic [1:0] exp_e,
                           input int exp_hs, input int hs0);
    tests++;
    if (error !== exp_e) begin
      fails++;
      $display("FAIL %s_error got %0d required %0d", name, error, exp_e);
    end
    tests++;
    if (hs_cnt - hs0 !== exp_hs) begin
      fails++;
      $display("FAIL %s_txn_count got %0d required %0d", name, hs_cnt - hs0, exp_hs);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_scoreboard got %0d pending required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({busy, done, error, m_valid, m_wstrb} !== '0 ||
        m_address !== '0 || m_wdata !== '0 ||
        last_rdata !== '0 || err_idx !== '0) begin
      fails++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%0d valid=%b required all 0",
               busy, done, error, m_valid);
    end
  endtask

  task automatic test_write_seq();
    int h0;
    lat = 2; never = 1'b0;
    prog(0, 2'd0, 16'h0000, 32'h0000A080, 4'hF);
    prog(1, 2'd0, 16'h0000, 32'h0000A480, 4'hF);
    prog(2, 2'd3, 16'h0000, 32'h0, 4'h0);
    push_exp(16'h0000, 32'h0000A080, 4'hF, 1'b1);
    push_exp(16'h0000, 32'h0000A480, 4'hF, 1'b1);
    h0 = hs_cnt;
    pulse_start();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL write_busy got %b required 1", busy);
    end
    wait_done("write");
    check_err("write", 2'd0, 2, h0);
  endtask

  task automatic run_cmp(input string name, input logic [SW-1:0] s,
                         input logic [DW-1:0] rd, input logic [1:0] exp_e);
    int h0;
    lat = 1; never = 1'b0;
    m_rdata = rd;
    prog(0, 2'd2, 16'h0000, 32'h0000A480, s);
    prog(1, 2'd3, 16'h0000, 32'h0, 4'h0);
    push_exp(16'h0000, 32'h0, 4'h0, 1'b0);
    h0 = hs_cnt;
    pulse_start();
    wait_done(name);
    check_err(name, exp_e, 1, h0);
    tests++;
    if (last_rdata !== rd) begin
      fails++;
      $display("FAIL %s_last_rdata got %h required %h", name, last_rdata, rd);
    end
    tests++;
    if (err_idx !== '0) begin
      fails++;
      $display("FAIL %s_err_idx got %0d required 0", name, err_idx);
    end
  endtask

  task automatic test_read_cmp();
    run_cmp("cmp_match", 4'hF, 32'h0000A480, 2'd0);
    run_cmp("cmp_mismatch", 4'hF, 32'h0000A481, 2'd2);
    run_cmp("cmp_masked", 4'hE, 32'h0000A481, 2'd0);
  endtask

  task automatic test_timeout();
    int h0;
    never = 1'b1;
    prog(0, 2'd0, 16'h0044, 32'h12345678, 4'hF);
    prog(1, 2'd3, 16'h0000, 32'h0, 4'h0);
    h0 = hs_cnt;
    vcnt = 0;
    pulse_start();
    wait_done("timeout");
    check_err("timeout", 2'd1, 0, h0);
    tests++;
    if (vcnt !== 15) begin
      fails++;
      $display("FAIL timeout_valid_cycles got %0d required 15", vcnt);
    end
    tests++;
    if (m_valid !== 1'b0 || err_idx !== '0) begin
      fails++;
      $display("FAIL timeout_drop got valid=%b idx=%0d required valid=0 idx=0",
               m_valid, err_idx);
    end
    never = 1'b0;
  endtask

  task automatic test_back_to_back();
    int h0;
    lat = 0; never = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      prog(i, 2'd0, AW'(16'h0100 + i * 4), DW'(32'hC0DE0000 + i), SW'(i + 1));
      push_exp(AW'(16'h0100 + i * 4), DW'(32'hC0DE0000 + i), SW'(i + 1), 1'b1);
    end
    h0 = hs_cnt;
    pulse_start();
    repeat (4) @(negedge clk_i);
    start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    wait_done("full");
    repeat (10) @(negedge clk_i);
    check_err("full", 2'd0, DEPTH, h0);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL full_idle_busy got %b required 0", busy);
    end
  endtask

  task automatic test_abort();
    int h0;
    lat = 3; never = 1'b0;
    prog(0, 2'd0, 16'h0010, 32'h11111111, 4'hF);
    prog(1, 2'd0, 16'h0014, 32'h22222222, 4'hF);
    prog(2, 2'd0, 16'h0018, 32'h33333333, 4'hF);
    prog(3, 2'd3, 16'h0000, 32'h0, 4'h0);
    push_exp(16'h0010, 32'h11111111, 4'hF, 1'b1);
    push_exp(16'h0014, 32'h22222222, 4'hF, 1'b1);
    h0 = hs_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (m_valid && hs_cnt - h0 == 1) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL abort_slot1_req got none required REQ within 100 cycles");
    end
    abort = 1'b1;
    @(negedge clk_i);
    abort = 1'b0;
    wait_done("abort");
    check_err("abort", 2'd3, 2, h0);
    tests++;
    if (err_idx !== 3'd1) begin
      fails++;
      $display("FAIL abort_err_idx got %0d required 1", err_idx);
    end
  endtask

  task automatic test_arst();
    int h0;
    never = 1'b1;
    prog(0, 2'd0, 16'h0020, 32'hAAAA0001, 4'hF);
    prog(1, 2'd0, 16'h0024, 32'hAAAA0002, 4'h3);
    prog(2, 2'd3, 16'h0000, 32'h0, 4'h0);
    pulse_start();
    repeat (3) @(negedge clk_i);
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre_valid got %b required 1", m_valid);
    end
    arst_i = 1'b1;
    #1;
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL arst_async got valid=%b busy=%b required 0 0", m_valid, busy);
    end
    @(negedge clk_i);
    arst_i = 1'b0;
    never = 1'b0; lat = 0;
    push_exp(16'h0020, 32'hAAAA0001, 4'hF, 1'b1);
    push_exp(16'h0024, 32'hAAAA0002, 4'h3, 1'b1);
    h0 = hs_cnt;
    pulse_start();
    wait_done("arst_rerun");
    check_err("arst_rerun", 2'd0, 2, h0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    test_reset();
    arst_i = 1'b0;
    @(negedge clk_i);
    test_write_seq();
    test_read_cmp();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_arst();
    repeat (3) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iob_reg_seq.md
Name: iob_reg_seq

Overview:
- Parametrised IOb-native bus master that replays a programmable list of register commands (write, read, read-and-compare) into a peripheral such as the Ethernet MAC wrapper.
- Issues one transaction at a time, waits for ready, and checks read data where requested.
- Detects hung slaves by timeout.
- Sits between a control CPU or boot logic and any IOb-native slave; used to bring up MODER/loopback configuration without software.

Parameters:
- ADDR_W, 16, master address width.
- DATA_W, 32, master data width; a multiple of 8.
- DEPTH, 16, number of command slots; a power of 2, at least 2.
- TIMEOUT_W, 8, width of the ready-wait counter; timeout = 2^TIMEOUT_W-1 cycles.

Ports:
- clk_i  in  1  system clock
- arst_i  in  1  asynchronous active-high reset
- cmd_we  in  1  command slot write enable; ignored while busy
- cmd_idx  in  $clog2(DEPTH)  slot index
- cmd_op  in  2  opcode: 0=WRITE, 1=READ, 2=READ_CMP, 3=END
- cmd_addr  in  ADDR_W  target address
- cmd_data  in  DATA_W  write data / compare value
- cmd_strb  in  DATA_W/8  write strobe / compare byte mask
- start  in  1  one-cycle pulse; begins execution at slot 0
- abort  in  1  stop after the current transaction
- busy  out  1  sequence running
- done  out  1  one-cycle pulse at sequence end, success or error
- error  out  2  0=none, 1=timeout, 2=compare mismatch, 3=aborted; held until next start
- err_idx  out  $clog2(DEPTH)  slot that caused the error
- last_rdata  out  DATA_W  data captured by the most recent READ/READ_CMP
- m_valid  out  1  IOb request valid
- m_address  out  ADDR_W  IOb address
- m_wdata  out  DATA_W  IOb write data
- m_wstrb  out  DATA_W/8  IOb strobe; 0 for reads
- m_rdata  in  DATA_W  IOb read data
- m_ready  in  1  IOb ready/response

Behaviour:
- Reset: all outputs 0; state IDLE; pointer 0; timeout counter 0. Command memory contents are not reset.
- Command memory writes take effect on the next clk_i edge and only when not busy.
- FSM states: IDLE, FETCH, REQ, DONE.
- IDLE:
  - start=1 → FETCH; pointer=0; error=0; busy=1 from the next cycle.
  - start while busy is ignored.
- FETCH (1 cycle):
  - Synchronous read of slot[pointer]; registers the m_* fields.
  - If op=END → DONE.
  - If abort is sampled → DONE with error=3.
  - Otherwise → REQ.
- REQ:
  - m_valid=1; m_address, m_wdata and m_wstrb are stable and held until the cycle m_ready=1.
  - For READ/READ_CMP, m_wstrb=0.
  - The transaction completes in the cycle m_valid&m_ready. The next cycle m_valid=0, and m_rdata is captured into last_rdata for reads.
  - READ_CMP mismatch: compare (m_rdata & M) against (cmd_data & M), where M is cmd_strb expanded per byte. Mismatch → DONE with error=2, err_idx=pointer.
  - Timeout: the counter increments each REQ cycle without ready. Reaching 2^TIMEOUT_W-1 → DONE with error=1, err_idx=pointer, m_valid dropped.
  - On success: if pointer=DEPTH-1, go to DONE (no wrap). Otherwise pointer+1, back to FETCH, counter cleared.
  - abort is latched during REQ and acted on after the transaction completes: DONE with error=3, unless that transaction already produced error 1 or 2, which take priority.
- DONE (1 cycle): done=1; busy=0 next cycle; → IDLE.
- Minimum cost per command: 2 cycles with zero-wait ready, i.e. FETCH, then REQ with ready.
- Reset mid-operation: m_valid drops asynchronously; pending state is discarded.

Decomposition:
- Package iob_reg_seq_pkg holds:
  - opcode constants (OP_WRITE, OP_READ, OP_READ_CMP, OP_END);
  - error codes (ERR_NONE, ERR_TIMEOUT, ERR_CMP, ERR_ABORT);
  - FSM state encoding;
  - CMD_W = 2+ADDR_W+DATA_W+DATA_W/8.
- One sub-module, iob_reg_seq_mem: DEPTH x CMD_W register file with one write port and a registered read port.

Test Plan:
- Slots {WRITE 0x0000 0x0000A080 strb 0xF; WRITE 0x0000 0x0000A480 0xF; END}, slave ready after 2 cycles → two handshakes with the exact address/wdata values, done pulse, error=0.
- READ_CMP 0x0000 expect 0x0000A480 strb 0xF against a slave returning 0x0000A480 → error=0, last_rdata=0x0000A480. Slave returning 0x0000A481 → error=2, err_idx=0. Same mismatch with strb 0xE → error=0.
- Slave never ready, TIMEOUT_W=4 → m_valid high for exactly 15 cycles, then error=1, done pulse, m_valid=0.
- All DEPTH slots WRITE with no END → exactly DEPTH transactions, then done. A start pulse mid-run is ignored (count unchanged).
- abort pulsed during slot 1 REQ → slot 1 completes, no slot 2 request, error=3. Separately, arst_i asserted during REQ → m_valid=0 and busy=0 immediately; a fresh start then reruns from slot 0.
